sram_mem_controller: RTL

//  CPU-side initiator for the external 16-bit asynchronous-style SRAM bus.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_wait_counter.sv | 34 +++
 rtl/sram_mem_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the 16-bit external SRAM controller.
//   sram_state_t      controller FSM states
//   SRAM_AW / SRAM_DW SRAM halfword address and data widths
//   DEFAULT_BASE_ADDR CPU byte address that maps to SRAM word 0
//   word_index()      CPU byte address -> 17-bit SRAM word index (wraps)
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Addresses below the base or beyond 2^17 words wrap modulo the SRAM size.
    function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
        return (SRAM_AW-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that times one halfword phase.
//   clk   in   system clock
//   rst   in   synchronous active-high reset (count -> 0)
//   load  in   start a new phase; count loads ACCESS_CYCLES-1
//   last  out  high on the final cycle of the phase (terminal count)
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(ACCESS_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage initiator for a 16-bit asynchronous SRAM.
// Splits each 32-bit load/store into a low-half then a high-half access and
// holds ready low until the word completes.
//   clk, rst            system clock, synchronous active-high reset
//   wr_en, rd_en        store / load request (level, held while ready=0)
//   address, write_data CPU byte address (word aligned) and store data
//   read_data, ready    load result (valid while ready=1 after a read), stall
//   SRAM_DQ             bidirectional data, driven only in write phases
//   SRAM_ADDR           halfword address {word, half}
//   SRAM_WE_N/OE_N      write / output enable (active low)
//   SRAM_UB_N/LB_N/CE_N tied low
//
// state | meaning
// IDLE  | no access on the bus; accepts a request (ready drops that cycle)
// LOW   | low halfword access, ACCESS_CYCLES cycles
// HIGH  | high halfword access, ACCESS_CYCLES cycles
// DONE  | bus idle, ready=1 for one cycle, then IDLE
module sram_mem_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    sram_state_t          state;
    logic                 op_write;
    logic [SRAM_AW-2:0]   word_q;
    logic [SRAM_DW-1:0]   wdata_hi_q;
    logic [SRAM_DW-1:0]   dq_out;
    logic                 dq_oe;
    logic                 req;
    logic                 cnt_load;
    logic                 cnt_last;
    logic [SRAM_AW-2:0]   req_word;

    assign req      = rd_en | wr_en;
    assign req_word = word_index(address, BASE_ADDR);

    // A phase starts on acceptance (LOW) and on the LOW->HIGH hand-over.
    assign cnt_load = ((state == IDLE) && req) || ((state == LOW) && cnt_last);

    sram_wait_counter #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .last (cnt_last)
    );

    // ready is combinational so the pipeline freezes in the acceptance cycle.
    assign ready = (state == DONE) || ((state == IDLE) && !req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            word_q     <= '0;
            wdata_hi_q <= '0;
            read_data  <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous load and store is handled as a store.
                        state      <= LOW;
                        op_write   <= wr_en;
                        word_q     <= req_word;
                        wdata_hi_q <= write_data[31:16];
                        SRAM_ADDR  <= {req_word, 1'b0};
                        SRAM_WE_N  <= ~wr_en;
                        SRAM_OE_N  <= wr_en;
                        dq_oe      <= wr_en;
                        dq_out     <= write_data[15:0];
                    end
                end
                LOW: begin
                    if (cnt_last) begin
                        if (!op_write) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                        state     <= HIGH;
                        SRAM_ADDR <= {word_q, 1'b1};
                        dq_out    <= wdata_hi_q;
                    end
                end
                HIGH: begin
                    if (cnt_last) begin
                        if (!op_write) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 'z;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule
